// File: rtl/fft_stage_sequencer.sv
// Stage/slot sequencer for the 4-MAC radix-2 butterfly datapath of the 32-point FFT:
// issue control, per-MAC twiddle addresses, ping-pong bank selects and write-back tags.
module fft_stage_sequencer #(
    parameter int N_POINTS = 32,
    parameter int LOG2N    = 5,
    parameter int NUM_MAC  = 4,
    parameter int MAC_LAT  = 2,
    parameter int TW_AW    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    output logic [1:0]               mac_sel,
    output logic [2:0]               stage,
    output logic                     issue_valid,
    output logic [NUM_MAC*TW_AW-1:0] tw_addr,
    output logic                     wb_valid,
    output logic [1:0]               wb_sel,
    output logic [2:0]               wb_stage,
    output logic                     rd_bank,
    output logic                     wr_bank,
    output logic                     busy,
    output logic                     done
);

    localparam int         SLOTS      = N_POINTS / (2 * NUM_MAC);
    localparam logic [1:0] LAST_SLOT  = 2'(SLOTS - 1);
    localparam logic [2:0] LAST_STAGE = 3'(LOG2N - 1);
    localparam int         CNT_W      = $clog2(MAC_LAT + 1);
    localparam int         WB_W       = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mac_sel_q, mac_sel_d;
    logic [2:0]       stage_q, stage_d;
    logic             rd_bank_q, rd_bank_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic [WB_W-1:0]  wb_pipe_q [MAC_LAT];
    logic [WB_W-1:0]  wb_pipe_d [MAC_LAT];
    logic             issue;

    // Butterfly b = sel*NUM_MAC + m uses twiddle (b mod 2^stg) scaled to the full ROM range.
    function automatic logic [TW_AW-1:0] tw_calc(input logic [1:0] sel,
                                                 input logic [2:0] stg,
                                                 input int         m);
        int b;
        int j;
        b = int'(sel) * NUM_MAC + m;
        j = b & ((1 << int'(stg)) - 1);
        return TW_AW'(j << (LOG2N - 1 - int'(stg)));
    endfunction

    assign issue = (state_q == S_RUN) && !stall;

    always_comb begin
        state_d   = state_q;
        mac_sel_d = mac_sel_q;
        stage_d   = stage_q;
        rd_bank_d = rd_bank_q;
        drain_d   = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    mac_sel_d = 2'd0;
                    stage_d   = 3'd0;
                    rd_bank_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (mac_sel_q == LAST_SLOT) begin
                        state_d = S_DRAIN;
                        drain_d = CNT_W'(MAC_LAT);
                    end else begin
                        mac_sel_d = mac_sel_q + 2'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == CNT_W'(1)) begin
                    if (stage_q < LAST_STAGE) begin
                        state_d   = S_RUN;
                        stage_d   = stage_q + 3'd1;
                        mac_sel_d = 2'd0;
                        rd_bank_d = ~rd_bank_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Write-back tags advance every cycle so results line up with their issue slot.
    always_comb begin
        for (int i = MAC_LAT - 1; i > 0; i--) begin
            wb_pipe_d[i] = wb_pipe_q[i-1];
        end
        wb_pipe_d[0] = {issue, mac_sel_q, stage_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mac_sel_q <= 2'd0;
            stage_q   <= 3'd0;
            rd_bank_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_q   <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                wb_pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mac_sel_q <= mac_sel_d;
            stage_q   <= stage_d;
            rd_bank_q <= rd_bank_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drain_q   <= drain_d;
            for (int i = 0; i < MAC_LAT; i++) begin
                wb_pipe_q[i] <= wb_pipe_d[i];
            end
        end
    end

    always_comb begin
        tw_addr = '0;
        for (int m = 0; m < NUM_MAC; m++) begin
            tw_addr[m*TW_AW +: TW_AW] = tw_calc(mac_sel_q, stage_q, m);
        end
    end

    assign mac_sel     = mac_sel_q;
    assign stage       = stage_q;
    assign issue_valid = issue;
    assign wb_valid    = wb_pipe_q[MAC_LAT-1][5];
    assign wb_sel      = wb_pipe_q[MAC_LAT-1][4:3];
    assign wb_stage    = wb_pipe_q[MAC_LAT-1][2:0];
    assign rd_bank     = rd_bank_q;
    assign wr_bank     = ~rd_bank_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
